// File: rtl/ocr_pkg.sv
// ocr_pkg: shared OCR feature-stage types: pixel width, feature record, accumulator FSM states.
package ocr_pkg;

    localparam int PIX_W      = 32;
    localparam int FEAT_IDX_W = 16;
    localparam int FEAT_INK_W = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } feat_state_t;

    // Sized generously so one record type serves every ROWS setting; the top slices it down.
    typedef struct packed {
        logic [FEAT_INK_W-1:0] ink;
        logic [FEAT_IDX_W-1:0] top;
        logic [FEAT_IDX_W-1:0] bottom;
        logic [PIX_W-1:0]      cols;
        logic                  empty;
    } feat_rec_t;

endpackage

// File: rtl/row_feature_accum_popcount32.sv
// popcount32: combinational count of set bits in a 32-bit word.
module popcount32 (
    input  logic [31:0] d,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++)
            cnt = cnt + 6'(d[i]);
    end

endmodule

// File: rtl/row_feature_accum.sv
// row_feature_accum: accumulates ink, vertical extent and column occupancy over ROWS-row frames.
// Define ROW_FEAT_SOF_EN to add the row_sof start-of-frame input.
module row_feature_accum
    import ocr_pkg::*;
#(
    parameter int ROWS  = 32,
    parameter int IDX_W = $clog2(ROWS + 1),
    parameter int INK_W = $clog2(32 * ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      row_data,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             feat_valid,
    input  logic             feat_ready,
    output logic [INK_W-1:0] feat_ink,
    output logic [IDX_W-1:0] feat_top,
    output logic [IDX_W-1:0] feat_bottom,
    output logic [31:0]      feat_cols,
    output logic             feat_empty
`ifdef ROW_FEAT_SOF_EN
    ,
    input  logic             row_sof
`endif
);

    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

    feat_state_t      state_q, state_d;
    logic             row_ready_q, row_ready_d;
    logic             feat_valid_q, feat_valid_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [INK_W-1:0] ink_q, ink_d;
    logic [31:0]      cols_q, cols_d;
    logic [IDX_W-1:0] top_q, top_d;
    logic [IDX_W-1:0] bot_q, bot_d;
    feat_rec_t        feat_q, feat_d;

    logic             acc, sof, last, nz;
    logic [5:0]       pc;
    logic [IDX_W-1:0] cnt_b, top_b, bot_b, top_n, bot_n;
    logic [INK_W-1:0] ink_b, ink_n;
    logic [31:0]      cols_b, cols_n;
    logic             unused_ok;

    popcount32 u_pc (.d(row_data), .cnt(pc));

    assign acc = row_valid && row_ready_q;
`ifdef ROW_FEAT_SOF_EN
    assign sof = acc && row_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame row sees freshly cleared accumulators, so partial frames vanish.
    assign cnt_b  = sof ? '0 : cnt_q;
    assign ink_b  = sof ? '0 : ink_q;
    assign cols_b = sof ? '0 : cols_q;
    assign top_b  = sof ? IDX_NONE : top_q;
    assign bot_b  = sof ? IDX_NONE : bot_q;

    assign nz     = |row_data;
    assign ink_n  = ink_b + INK_W'(pc);
    assign cols_n = cols_b | row_data;
    assign top_n  = (nz && top_b == IDX_NONE) ? cnt_b : top_b;
    assign bot_n  = nz ? cnt_b : bot_b;
    assign last   = cnt_b == IDX_LAST;

    always_comb begin
        state_d      = state_q;
        row_ready_d  = row_ready_q;
        feat_valid_d = feat_valid_q;
        cnt_d        = cnt_q;
        ink_d        = ink_q;
        cols_d       = cols_q;
        top_d        = top_q;
        bot_d        = bot_q;
        feat_d       = feat_q;
        if (acc && last) begin
            cnt_d         = '0;
            ink_d         = '0;
            cols_d        = '0;
            top_d         = IDX_NONE;
            bot_d         = IDX_NONE;
            feat_d.ink    = FEAT_INK_W'(ink_n);
            feat_d.top    = FEAT_IDX_W'(top_n);
            feat_d.bottom = FEAT_IDX_W'(bot_n);
            feat_d.cols   = cols_n;
            feat_d.empty  = ink_n == '0;
            state_d       = DONE;
            row_ready_d   = 1'b0;
            feat_valid_d  = 1'b1;
        end else if (acc) begin
            cnt_d  = cnt_b + IDX_W'(1);
            ink_d  = ink_n;
            cols_d = cols_n;
            top_d  = top_n;
            bot_d  = bot_n;
        end else if (feat_valid_q && feat_ready) begin
            state_d      = ACCUM;
            row_ready_d  = 1'b1;
            feat_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            row_ready_q  <= 1'b1;
            feat_valid_q <= 1'b0;
            cnt_q        <= '0;
            ink_q        <= '0;
            cols_q       <= '0;
            top_q        <= IDX_NONE;
            bot_q        <= IDX_NONE;
            feat_q       <= '{ink: '0, top: FEAT_IDX_W'(ROWS), bottom: FEAT_IDX_W'(ROWS),
                              cols: '0, empty: 1'b1};
        end else begin
            state_q      <= state_d;
            row_ready_q  <= row_ready_d;
            feat_valid_q <= feat_valid_d;
            cnt_q        <= cnt_d;
            ink_q        <= ink_d;
            cols_q       <= cols_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            feat_q       <= feat_d;
        end
    end

    assign row_ready   = row_ready_q;
    assign feat_valid  = feat_valid_q;
    assign feat_ink    = feat_q.ink[INK_W-1:0];
    assign feat_top    = feat_q.top[IDX_W-1:0];
    assign feat_bottom = feat_q.bottom[IDX_W-1:0];
    assign feat_cols   = feat_q.cols;
    assign feat_empty  = feat_q.empty;
    assign unused_ok   = ^{feat_q.ink, feat_q.top, feat_q.bottom, state_q};

endmodule

// File: tb/tb_row_feature_accum.sv
// tb_row_feature_accum: directed checks of row_feature_accum with ROWS=4.
module tb_row_feature_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] row_data = '0;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic        feat_valid;
    logic        feat_ready = 1'b0;
    logic [7:0]  feat_ink;
    logic [2:0]  feat_top;
    logic [2:0]  feat_bottom;
    logic [31:0] feat_cols;
    logic        feat_empty;
`ifdef ROW_FEAT_SOF_EN
    logic        row_sof = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    row_feature_accum #(.ROWS(4)) dut (
        .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_valid(row_valid),
        .row_ready(row_ready), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_ink(feat_ink), .feat_top(feat_top), .feat_bottom(feat_bottom),
        .feat_cols(feat_cols), .feat_empty(feat_empty)
`ifdef ROW_FEAT_SOF_EN
        , .row_sof(row_sof)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_row(input logic [31:0] d);
        row_valid = 1'b1;
        row_data  = d;
        step();
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    task automatic check_rec(input string tag, input logic [7:0] ink, input logic [2:0] top,
                             input logic [2:0] bot, input logic [31:0] cols, input logic empty);
        check({tag, ".valid"}, feat_valid, 1);
        check({tag, ".row_ready"}, row_ready, 0);
        check({tag, ".ink"}, feat_ink, ink);
        check({tag, ".top"}, feat_top, top);
        check({tag, ".bottom"}, feat_bottom, bot);
        check({tag, ".cols"}, feat_cols, cols);
        check({tag, ".empty"}, feat_empty, empty);
    endtask

    task automatic accept_rec(input string tag);
        feat_ready = 1'b1;
        step();
        feat_ready = 1'b0;
        check({tag, ".ack_valid"}, feat_valid, 0);
        check({tag, ".ack_row_ready"}, row_ready, 1);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        check("rst.row_ready", row_ready, 1);
        check("rst.valid", feat_valid, 0);
        check("rst.top", feat_top, 4);
        check("rst.bottom", feat_bottom, 4);
        check("rst.ink", feat_ink, 0);
        check("rst.cols", feat_cols, 0);
        check("rst.empty", feat_empty, 1);

        // mixed frame, back-to-back rows
        row_valid = 1'b1;
        row_data = 32'h0;    step();
        row_data = 32'h00F0; step();
        row_data = 32'h0;    step();
        check("f1.valid_early", feat_valid, 0);
        row_data = 32'h8001; step();
        row_valid = 1'b0;
        check_rec("f1", 8'd6, 3'd1, 3'd3, 32'h80F1, 1'b0);
        accept_rec("f1");

        // all-zero frame with feat_ready held high: DONE still lasts a cycle
        feat_ready = 1'b1;
        repeat (4) send_row(32'h0);
        check_rec("f2", 8'd0, 3'd4, 3'd4, 32'h0, 1'b1);
        step();
        check("f2.ack_valid", feat_valid, 0);
        check("f2.ack_row_ready", row_ready, 1);
        feat_ready = 1'b0;

        // backpressure: record held, rows offered in DONE are ignored
        repeat (4) send_row(32'h3);
        for (int i = 0; i < 5; i++) begin
            row_valid = 1'b1;
            row_data  = 32'hFFFF_FFFF;
            step();
            check("bp.row_ready", row_ready, 0);
            check("bp.valid", feat_valid, 1);
            check("bp.ink", feat_ink, 8);
            check("bp.cols", feat_cols, 32'h3);
        end
        row_valid = 1'b0;
        accept_rec("bp");
        repeat (4) send_row(32'hFFFF_FFFF);
        check_rec("full", 8'd128, 3'd0, 3'd3, 32'hFFFF_FFFF, 1'b0);
        accept_rec("full");

        // reset mid-frame discards the partial frame
        repeat (2) send_row(32'hF0);
        rst_n = 1'b0;
        #2;
        check("midrst.row_ready", row_ready, 1);
        check("midrst.valid", feat_valid, 0);
        rst_n = 1'b1;
        step();
        repeat (4) send_row(32'h1);
        check_rec("after_rst", 8'd4, 3'd0, 3'd3, 32'h1, 1'b0);

        // reset while DONE drops the pending record
        rst_n = 1'b0;
        #2;
        check("donerst.valid", feat_valid, 0);
        check("donerst.ink", feat_ink, 0);
        check("donerst.empty", feat_empty, 1);
        check("donerst.top", feat_top, 4);
        rst_n = 1'b1;
        step();

`ifdef ROW_FEAT_SOF_EN
        send_row(32'hF);
        send_row(32'hF);
        row_sof = 1'b1;
        send_row(32'h1);
        row_sof = 1'b0;
        send_row(32'h0);
        send_row(32'h0);
        check("sof.valid_early", feat_valid, 0);
        send_row(32'h0);
        check_rec("sof", 8'd1, 3'd0, 3'd0, 32'h1, 1'b0);
        accept_rec("sof");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
